sys_counter_unit: RTL and testbench

Execute-stage system unit that carries out the `t_sysop` commands issued by the decode-stage control unit. It holds the 64-bit cycle, time and instret counters, returns the requested 32-bit half for the RD* operations, and raises a trap request for SCALL/SBREAK. It holds the pipeline until the trap is acknowledged. It sits beside the ALU and branch unit and is selected when `exe_unit == SYSTEM_UNIT`.

---
 rtl/multicore_pkg.sv | 38 +++
 rtl/sys_counter_unit_if.sv | 29 ++
 rtl/counter64.sv | 17 +
 rtl/sys_counter_unit.sv | 132 +++++++++++++
 tb/tb_sys_counter_unit.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicore_pkg.sv
// Shared types for the execute-stage units: system operations, the system-unit
// FSM states and trap cause codes.
package multicore_pkg;

  typedef enum logic [3:0] {
    SYS_RDCYCLE    = 4'd0,
    SYS_RDCYCLEH   = 4'd1,
    SYS_RDTIME     = 4'd2,
    SYS_RDTIMEH    = 4'd3,
    SYS_RDINSTRET  = 4'd4,
    SYS_RDINSTRETH = 4'd5,
    SYS_SCALL      = 4'd6,
    SYS_SBREAK     = 4'd7
  } t_sysop;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_TRAP = 1'b1
  } t_sys_state;

  localparam logic [3:0] CAUSE_ECALL = 4'd11;
  localparam logic [3:0] CAUSE_BREAK = 4'd3;

  // Unknown encodings behave as RDCYCLE, so they select the low half.
  function automatic logic is_high_half(input t_sysop op);
    logic hi;
    case (op)
      SYS_RDCYCLEH, SYS_RDTIMEH, SYS_RDINSTRETH: hi = 1'b1;
      default:                                   hi = 1'b0;
    endcase
    return hi;
  endfunction

  function automatic logic is_trap_op(input t_sysop op);
    return (op == SYS_SCALL) || (op == SYS_SBREAK);
  endfunction

endpackage

// File: rtl/sys_counter_unit_if.sv
// Request/response bundle between the execute stage and the system counter unit.
interface sys_counter_unit_if;
  import multicore_pkg::*;

  logic        valid;
  t_sysop      sysop;
  logic        retire;
  logic        trap_ack;
  logic        rsp_valid;
  logic [31:0] result;
  logic        trap;
  logic [3:0]  cause;
  logic        busy;
  t_sys_state  state;

  // A request (valid, sysop) is taken on any rising edge where busy is low and
  // ignored while busy is high; rsp_valid is a single-cycle response with no
  // back-pressure; trap is a level that stays high until trap_ack is sampled.
  modport master (
    output valid, sysop, retire, trap_ack,
    input  rsp_valid, result, trap, cause, busy, state
  );

  modport slave (
    input  valid, sysop, retire, trap_ack,
    output rsp_valid, result, trap, cause, busy, state
  );

endinterface

// File: rtl/counter64.sv
// Free-running 64-bit counter with count enable and asynchronous active-low clear.
module counter64 (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        en,
  output logic [63:0] count
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en) begin
      count <= count + 64'd1;
    end
  end

endmodule

// File: rtl/sys_counter_unit.sv
// Execute-stage system unit: cycle/time/instret counters with 32-bit half reads,
// and SCALL/SBREAK trap requests that stall the pipeline until acknowledged.
module sys_counter_unit
  import multicore_pkg::*;
#(
  parameter int unsigned TIME_DIV = 100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  t_sysop      i_sysop,
  input  logic        i_retire,
  input  logic        i_trap_ack,
  output logic        o_valid,
  output logic [31:0] o_result,
  output logic        o_trap,
  output logic [3:0]  o_cause,
  output logic        o_busy,
  output t_sys_state  o_state
);

  localparam int unsigned PRE_W = (TIME_DIV > 1) ? $clog2(TIME_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TIME_DIV - 1);

  logic [PRE_W-1:0] prescale;
  logic             time_tick;
  logic [63:0]      cycle_cnt;
  logic [63:0]      time_cnt;
  logic [63:0]      instret_cnt;

  t_sys_state  state;
  t_sys_state  state_nx;
  logic        valid_nx;
  logic [31:0] result_nx;
  logic [3:0]  cause_nx;
  logic [63:0] read_src;
  logic [31:0] read_half;

  // With TIME_DIV == 1 the prescaler sits at 0 == PRE_LAST, so time ticks every clock.
  assign time_tick = (prescale == PRE_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prescale <= '0;
    end else if (time_tick) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + PRE_W'(1);
    end
  end

  counter64 u_cycle (
    .clk   (i_clk),
    .clr_n (i_rst_n),
    .en    (1'b1),
    .count (cycle_cnt)
  );

  counter64 u_time (
    .clk   (i_clk),
    .clr_n (i_rst_n),
    .en    (time_tick),
    .count (time_cnt)
  );

  counter64 u_instret (
    .clk   (i_clk),
    .clr_n (i_rst_n),
    .en    (i_retire),
    .count (instret_cnt)
  );

  // Reads see the counters as registered before the accepting edge.
  always_comb begin
    read_src = cycle_cnt;
    case (i_sysop)
      SYS_RDTIME, SYS_RDTIMEH:       read_src = time_cnt;
      SYS_RDINSTRET, SYS_RDINSTRETH: read_src = instret_cnt;
      default:                       read_src = cycle_cnt;
    endcase
    read_half = is_high_half(i_sysop) ? read_src[63:32] : read_src[31:0];
  end

  always_comb begin
    state_nx  = state;
    valid_nx  = 1'b0;
    result_nx = o_result;
    cause_nx  = o_cause;
    case (state)
      S_IDLE: begin
        if (i_valid) begin
          if (is_trap_op(i_sysop)) begin
            state_nx = S_TRAP;
            cause_nx = (i_sysop == SYS_SCALL) ? CAUSE_ECALL : CAUSE_BREAK;
          end else begin
            valid_nx  = 1'b1;
            result_nx = read_half;
          end
        end
      end
      S_TRAP: begin
        if (i_trap_ack) begin
          state_nx = S_IDLE;
          cause_nx = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cause_nx = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_cause  <= '0;
    end else begin
      state    <= state_nx;
      o_valid  <= valid_nx;
      o_result <= result_nx;
      o_cause  <= cause_nx;
    end
  end

  assign o_trap  = (state == S_TRAP);
  assign o_busy  = (state == S_TRAP);
  assign o_state = state;

endmodule

// File: tb/tb_sys_counter_unit.sv
// Bench for sys_counter_unit: fixed vectors, corner sequences and random traffic
// checked against a counting model of cycle/time/instret and the trap handshake.
module tb_sys_counter_unit;
  import multicore_pkg::*;

  localparam int unsigned DIV_A = 4;
  localparam int unsigned DIV_B = 1;

  logic clk;
  logic rst_n;

  sys_counter_unit_if bus ();
  sys_counter_unit_if bus1 ();

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp1_q[$];

  // Model state: edges and retires seen since reset, plus an offset for forced cycle values.
  logic [63:0] n_edges;
  logic [63:0] n_retire;
  logic [63:0] cyc_base;
  logic        m_trap;
  logic [3:0]  m_cause;

  typedef struct {
    logic [3:0]  op;
    int          idle;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  sys_counter_unit #(.TIME_DIV(DIV_A)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (bus.valid),
    .i_sysop    (bus.sysop),
    .i_retire   (bus.retire),
    .i_trap_ack (bus.trap_ack),
    .o_valid    (bus.rsp_valid),
    .o_result   (bus.result),
    .o_trap     (bus.trap),
    .o_cause    (bus.cause),
    .o_busy     (bus.busy),
    .o_state    (bus.state)
  );

  sys_counter_unit #(.TIME_DIV(DIV_B)) dut1 (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_valid    (bus.valid),
    .i_sysop    (bus.sysop),
    .i_retire   (bus.retire),
    .i_trap_ack (bus.trap_ack),
    .o_valid    (bus1.rsp_valid),
    .o_result   (bus1.result),
    .o_trap     (bus1.trap),
    .o_cause    (bus1.cause),
    .o_busy     (bus1.busy),
    .o_state    (bus1.state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] pick(input logic [3:0] op, input logic [63:0] cyc,
                                       input logic [63:0] tim, input logic [63:0] ins);
    logic [63:0] v;
    logic        hi;
    v  = cyc;
    hi = 1'b0;
    case (op)
      4'd1: hi = 1'b1;
      4'd2: v = tim;
      4'd3: begin v = tim; hi = 1'b1; end
      4'd4: v = ins;
      4'd5: begin v = ins; hi = 1'b1; end
      default: ;
    endcase
    return hi ? v[63:32] : v[31:0];
  endfunction

  task automatic reset_model();
    n_edges  = '0;
    n_retire = '0;
    cyc_base = '0;
    m_trap   = 1'b0;
    m_cause  = '0;
    exp_q.delete();
    exp1_q.delete();
  endtask

  // One clock: predict from pre-edge counts, advance, then compare #1 after the edge.
  task automatic clk_step();
    logic       pushed;
    logic [3:0] op;
    pushed = 1'b0;
    op     = bus.sysop;
    if (m_trap) begin
      if (bus.trap_ack) begin
        m_trap  = 1'b0;
        m_cause = 4'd0;
      end
    end else if (bus.valid) begin
      if (op == 4'd6) begin
        m_trap  = 1'b1;
        m_cause = 4'd11;
      end else if (op == 4'd7) begin
        m_trap  = 1'b1;
        m_cause = 4'd3;
      end else begin
        exp_q.push_back(pick(op, cyc_base + n_edges, n_edges / 64'(DIV_A), n_retire));
        exp1_q.push_back(pick(op, n_edges, n_edges / 64'(DIV_B), n_retire));
        pushed = 1'b1;
      end
    end
    @(posedge clk);
    n_edges  = n_edges + 64'd1;
    n_retire = n_retire + 64'(bus.retire);
    #1;
    check("o_valid", 64'(bus.rsp_valid), 64'(pushed));
    check("dut1 o_valid", 64'(bus1.rsp_valid), 64'(pushed));
    if (pushed) begin
      check("o_result", 64'(bus.result), 64'(exp_q.pop_front()));
      check("dut1 o_result", 64'(bus1.result), 64'(exp1_q.pop_front()));
    end
    check("o_trap", 64'(bus.trap), 64'(m_trap));
    check("o_busy", 64'(bus.busy), 64'(m_trap));
    if (m_trap) check("o_cause", 64'(bus.cause), 64'(m_cause));
  endtask

  // Driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk_step();
  endtask

  task automatic issue(input logic [3:0] op);
    bus.valid = 1'b1;
    bus.sysop = t_sysop'(op);
    clk_step();
    bus.valid = 1'b0;
  endtask

  task automatic force_cycle(input logic [63:0] v);
    force dut.u_cycle.count = v;
    cyc_base = v - n_edges;
    #1;
    release dut.u_cycle.count;
  endtask

  initial begin
    vecs[0] = '{op: 4'd0,  idle: 9, exp: 32'd9};
    vecs[1] = '{op: 4'd1,  idle: 0, exp: 32'd0};
    vecs[2] = '{op: 4'd2,  idle: 5, exp: 32'd4};
    vecs[3] = '{op: 4'd0,  idle: 0, exp: 32'd17};
    vecs[4] = '{op: 4'hC,  idle: 0, exp: 32'd18};
    vecs[5] = '{op: 4'd3,  idle: 2, exp: 32'd0};
    vecs[6] = '{op: 4'd4,  idle: 0, exp: 32'd0};
    vecs[7] = '{op: 4'd2,  idle: 0, exp: 32'd5};

    rst_n        = 1'b0;
    bus.valid    = 1'b0;
    bus.sysop    = SYS_RDCYCLE;
    bus.retire   = 1'b0;
    bus.trap_ack = 1'b0;
    reset_model();
    #12;
    check("reset o_valid", 64'(bus.rsp_valid), 64'd0);
    check("reset o_result", 64'(bus.result), 64'd0);
    check("reset o_trap", 64'(bus.trap), 64'd0);
    check("reset o_cause", 64'(bus.cause), 64'd0);
    check("reset o_busy", 64'(bus.busy), 64'd0);
    check("reset state", 64'(bus.state), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      idle(vecs[i].idle);
      issue(vecs[i].op);
      check($sformatf("vec%0d result", i), 64'(bus.result), 64'(vecs[i].exp));
    end

    // Retire on five edges, reading instret on the fifth.
    bus.retire = 1'b1;
    idle(4);
    issue(4'd4);
    check("instret on 5th retire", 64'(bus.result), 64'd4);
    bus.retire = 1'b0;
    issue(4'd4);
    check("instret after", 64'(bus.result), 64'd5);
    issue(4'd5);
    check("instret high", 64'(bus.result), 64'd0);

    issue(4'd2);
    check("div1 time equals cycle", 64'(bus1.result), 64'(n_edges[31:0] - 32'd1));

    // Low-to-high carry and full wrap of the cycle counter.
    force_cycle(64'h0000_0000_FFFF_FFFF);
    idle(1);
    issue(4'd1);
    check("cycle carry high", 64'(bus.result), 64'd1);
    force_cycle(64'h0000_0000_FFFF_FFFF);
    idle(1);
    issue(4'd0);
    check("cycle carry low", 64'(bus.result), 64'd0);
    force_cycle(64'hFFFF_FFFF_FFFF_FFFF);
    idle(1);
    issue(4'd0);
    check("cycle wrap low", 64'(bus.result), 64'd0);
    issue(4'd1);
    check("cycle wrap high", 64'(bus.result), 64'd0);

    // SCALL, ignored read during the trap, ack three cycles after entry.
    issue(4'd6);
    check("scall trap", 64'(bus.trap), 64'd1);
    check("scall cause", 64'(bus.cause), 64'd11);
    check("scall busy", 64'(bus.busy), 64'd1);
    issue(4'd0);
    check("read in trap ignored", 64'(bus.rsp_valid), 64'd0);
    idle(1);
    bus.trap_ack = 1'b1;
    clk_step();
    bus.trap_ack = 1'b0;
    check("ack trap drop", 64'(bus.trap), 64'd0);
    check("ack busy drop", 64'(bus.busy), 64'd0);
    check("ack cause drop", 64'(bus.cause), 64'd0);

    issue(4'd7);
    check("sbreak cause", 64'(bus.cause), 64'd3);
    bus.trap_ack = 1'b1;
    clk_step();
    bus.trap_ack = 1'b0;
    check("sbreak min trap", 64'(bus.trap), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.valid    = ($urandom_range(0, 2) != 0);
      bus.sysop    = t_sysop'(4'($urandom_range(0, 15)));
      bus.retire   = 1'($urandom_range(0, 1));
      bus.trap_ack = ($urandom_range(0, 3) == 0);
      clk_step();
    end
    bus.valid    = 1'b0;
    bus.retire   = 1'b0;
    bus.trap_ack = 1'b0;
    if (m_trap) begin
      bus.trap_ack = 1'b1;
      clk_step();
      bus.trap_ack = 1'b0;
    end

    // Asynchronous reset between edges while trapped.
    issue(4'd6);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst trap", 64'(bus.trap), 64'd0);
    check("async rst busy", 64'(bus.busy), 64'd0);
    check("async rst dut1 trap", 64'(bus1.trap), 64'd0);
    reset_model();
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    issue(4'd0);
    check("cycle after reset", 64'(bus.result), 64'd3);
    issue(4'd4);
    check("instret after reset", 64'(bus.result), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
